// File: rtl/control_pkg.sv
// Shared encodings for the multicycle control unit: opcodes, FSM states,
// datapath select codes and the packed control vector.
package control_pkg;

  localparam logic [3:0] OP_NOP  = 4'h0;
  localparam logic [3:0] OP_AADD = 4'h1;
  localparam logic [3:0] OP_ASUB = 4'h2;
  localparam logic [3:0] OP_JUMP = 4'h3;
  localparam logic [3:0] OP_HALT = 4'hF;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_LOAD_A = 4'd2,
    ST_LOAD_B = 4'd3,
    ST_EXEC   = 4'd4,
    ST_WB     = 4'd5,
    ST_STORE  = 4'd6,
    ST_JUMP   = 4'd7,
    ST_HALT   = 4'd8,
    ST_TRAP   = 4'd9
  } state_t;

  localparam logic [3:0] ALU_ADD        = 4'd2;
  localparam logic [3:0] ALU_SUB        = 4'd3;
  localparam logic [2:0] MEMDST_PC      = 3'd0;
  localparam logic [2:0] MEMDST_SHELLEY = 3'd3;
  localparam logic [2:0] PCSRC_PC_PLUS2 = 3'd0;
  localparam logic [2:0] PCSRC_IMM      = 3'd1;
  localparam logic [1:0] MEMSRC_MARY    = 2'd0;
  localparam logic [1:0] REGSRC_MEMVAL  = 2'd0;
  localparam logic [1:0] REGSRC_ALU     = 2'd1;

  typedef struct packed {
    logic       mem_write;
    logic       pc_write;
    logic       sp_write;
    logic       inst_write;
    logic [1:0] mem_src;
    logic [2:0] mem_dst;
    logic [2:0] pc_src;
    logic [2:0] sp_src;
    logic       mary_write;
    logic       shelley_write;
    logic       comp_write;
    logic       ra_write;
    logic [1:0] mary_src;
    logic [1:0] shelley_src;
    logic       ra_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [3:0] alu_op;
    logic       halted;
    logic       trap;
  } ctrl_t;

  function automatic logic [3:0] alu_for_op(input logic [3:0] op);
    case (op)
      OP_AADD: alu_for_op = ALU_ADD;
      OP_ASUB: alu_for_op = ALU_SUB;
      default: alu_for_op = 4'd0;
    endcase
  endfunction

endpackage

// File: rtl/control_outputs.sv
// Moore decode of FSM state plus latched opcode into the datapath control vector.
module control_outputs
  import control_pkg::*;
(
  input  state_t     state,
  input  logic [3:0] op,
  output ctrl_t      ctrl
);

  // Per-state control vector; anything not set here stays 0.
  always_comb begin
    ctrl = '0;
    case (state)
      ST_FETCH: begin
        ctrl.mem_dst    = MEMDST_PC;
        ctrl.pc_src     = PCSRC_PC_PLUS2;
        ctrl.pc_write   = 1'b1;
        ctrl.inst_write = 1'b1;
      end
      ST_DECODE: ctrl = '0;
      ST_LOAD_A: begin
        ctrl.mem_dst    = MEMDST_PC;
        ctrl.mary_src   = REGSRC_MEMVAL;
        ctrl.mary_write = 1'b1;
        ctrl.pc_write   = 1'b1;
        ctrl.pc_src     = PCSRC_PC_PLUS2;
      end
      ST_LOAD_B: begin
        ctrl.mem_dst       = MEMDST_PC;
        ctrl.shelley_src   = REGSRC_MEMVAL;
        ctrl.shelley_write = 1'b1;
      end
      ST_EXEC: begin
        ctrl.src_a  = 1'b0;
        ctrl.src_b  = 2'd0;
        ctrl.alu_op = alu_for_op(op);
      end
      ST_WB: begin
        ctrl.alu_op     = alu_for_op(op);
        ctrl.mary_src   = REGSRC_ALU;
        ctrl.mary_write = 1'b1;
      end
      ST_STORE: begin
        ctrl.mem_dst   = MEMDST_SHELLEY;
        ctrl.mem_src   = MEMSRC_MARY;
        ctrl.mem_write = 1'b1;
      end
      ST_JUMP: begin
        ctrl.pc_src   = PCSRC_IMM;
        ctrl.pc_write = 1'b1;
      end
      ST_HALT: ctrl.halted = 1'b1;
      ST_TRAP: begin
        ctrl.halted = 1'b1;
        ctrl.trap   = 1'b1;
      end
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/processor_control.sv
// Multicycle control FSM for the 16-bit stack/accumulator processor.
// Optional feature: define CONTROL_OVF_TRAP_EN to trap on ALU overflow in EXEC.
module processor_control
  import control_pkg::*;
#(
  parameter logic [2:0] RESET_PC_SRC = 3'd0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] instruction,
  input  logic        overflow_output,
  output logic        MemWrite,
  output logic        PCWrite,
  output logic        SPWrite,
  output logic        InstWrite,
  output logic [1:0]  MemSrc,
  output logic [2:0]  MemDst,
  output logic [2:0]  PCSrc,
  output logic [2:0]  SPSrc,
  output logic        mary_write,
  output logic        shelley_write,
  output logic        comp_write,
  output logic        ra_write,
  output logic [1:0]  mary_src,
  output logic [1:0]  shelley_src,
  output logic        ra_src,
  output logic        SrcA,
  output logic [1:0]  SrcB,
  output logic [3:0]  AluOp,
  output logic        halted,
  output logic        trap
);

  state_t     state;
  state_t     next_state;
  logic [3:0] op_q;
  ctrl_t      decoded;
  ctrl_t      ctrl;

`ifdef CONTROL_OVF_TRAP_EN
  logic unused_bits;
  assign unused_bits = ^instruction[11:0];
`else
  logic unused_bits;
  assign unused_bits = ^{instruction[11:0], overflow_output};
`endif

  // Next-state sequencing; HALT and TRAP only leave through reset.
  always_comb begin
    next_state = state;
    case (state)
      ST_FETCH:  next_state = ST_DECODE;
      ST_DECODE: begin
        case (instruction[15:12])
          OP_AADD, OP_ASUB: next_state = ST_LOAD_A;
          OP_JUMP:          next_state = ST_JUMP;
          OP_HALT:          next_state = ST_HALT;
          default:          next_state = ST_FETCH;
        endcase
      end
      ST_LOAD_A: next_state = ST_LOAD_B;
      ST_LOAD_B: next_state = ST_EXEC;
`ifdef CONTROL_OVF_TRAP_EN
      ST_EXEC: begin
        if (overflow_output) next_state = ST_TRAP;
        else                 next_state = ST_WB;
      end
`else
      ST_EXEC:   next_state = ST_WB;
`endif
      ST_WB:     next_state = ST_STORE;
      ST_STORE:  next_state = ST_FETCH;
      ST_JUMP:   next_state = ST_FETCH;
      ST_HALT:   next_state = ST_HALT;
      ST_TRAP:   next_state = ST_TRAP;
      default:   next_state = ST_FETCH;
    endcase
  end

  // State register and opcode latch (opcode captured only in DECODE).
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_FETCH;
      op_q  <= OP_NOP;
    end else begin
      state <= next_state;
      if (state == ST_DECODE) op_q <= instruction[15:12];
      else                    op_q <= op_q;
    end
  end

  control_outputs u_outputs (
    .state (state),
    .op    (op_q),
    .ctrl  (decoded)
  );

  // Reset blanks every enable in the same cycle so an aborted instruction writes nothing.
  always_comb begin
    ctrl = decoded;
    if (reset) begin
      ctrl        = '0;
      ctrl.pc_src = RESET_PC_SRC;
    end else begin
      ctrl = decoded;
    end
`ifndef CONTROL_OVF_TRAP_EN
    ctrl.trap = 1'b0;
`endif
  end

  assign MemWrite      = ctrl.mem_write;
  assign PCWrite       = ctrl.pc_write;
  assign SPWrite       = ctrl.sp_write;
  assign InstWrite     = ctrl.inst_write;
  assign MemSrc        = ctrl.mem_src;
  assign MemDst        = ctrl.mem_dst;
  assign PCSrc         = ctrl.pc_src;
  assign SPSrc         = ctrl.sp_src;
  assign mary_write    = ctrl.mary_write;
  assign shelley_write = ctrl.shelley_write;
  assign comp_write    = ctrl.comp_write;
  assign ra_write      = ctrl.ra_write;
  assign mary_src      = ctrl.mary_src;
  assign shelley_src   = ctrl.shelley_src;
  assign ra_src        = ctrl.ra_src;
  assign SrcA          = ctrl.src_a;
  assign SrcB          = ctrl.src_b;
  assign AluOp         = ctrl.alu_op;
  assign halted        = ctrl.halted;
  assign trap          = ctrl.trap;

endmodule

// File: tb/tb_processor_control.sv
// Randomized bench for processor_control against an instruction-script reference model.
module tb_processor_control;

`ifdef CONTROL_OVF_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam int S_FETCH = 0, S_DECODE = 1, S_LA = 2, S_LB = 3, S_EX = 4,
                 S_WB = 5, S_ST = 6, S_JUMP = 7, S_HALT = 8, S_TRAP = 9;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] instruction = 16'h0000;
  logic        overflow_output = 1'b0;
  logic        MemWrite, PCWrite, SPWrite, InstWrite;
  logic [1:0]  MemSrc;
  logic [2:0]  MemDst, PCSrc, SPSrc;
  logic        mary_write, shelley_write, comp_write, ra_write;
  logic [1:0]  mary_src, shelley_src;
  logic        ra_src, SrcA;
  logic [1:0]  SrcB;
  logic [3:0]  AluOp;
  logic        halted, trap;

  int compared = 0;
  int mismatched = 0;
  int steps[$];
  logic [3:0] cur_alu = 4'd0;
  int stuck = 0;

  processor_control dut (
    .clock(clock), .reset(reset), .instruction(instruction),
    .overflow_output(overflow_output),
    .MemWrite(MemWrite), .PCWrite(PCWrite), .SPWrite(SPWrite), .InstWrite(InstWrite),
    .MemSrc(MemSrc), .MemDst(MemDst), .PCSrc(PCSrc), .SPSrc(SPSrc),
    .mary_write(mary_write), .shelley_write(shelley_write),
    .comp_write(comp_write), .ra_write(ra_write),
    .mary_src(mary_src), .shelley_src(shelley_src), .ra_src(ra_src),
    .SrcA(SrcA), .SrcB(SrcB), .AluOp(AluOp), .halted(halted), .trap(trap)
  );

  always #5 clock = ~clock;

  logic [32:0] dut_vec;
  assign dut_vec = {MemWrite, PCWrite, SPWrite, InstWrite, MemSrc, MemDst, PCSrc, SPSrc,
                    mary_write, shelley_write, comp_write, ra_write, mary_src, shelley_src,
                    ra_src, SrcA, SrcB, AluOp, halted, trap};

  task automatic check_eq(input string tag, input logic [32:0] got, input logic [32:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic string step_name(input int s);
    case (s)
      S_FETCH: return "fetch";  S_DECODE: return "decode"; S_LA: return "load_a";
      S_LB: return "load_b";    S_EX: return "exec";       S_WB: return "wb";
      S_ST: return "store";     S_JUMP: return "jump";     S_HALT: return "halt";
      S_TRAP: return "trap";    default: return "unknown";
    endcase
  endfunction

  // Control vector each step is required to show, straight from the state table.
  function automatic logic [32:0] step_vec(input int s, input logic [3:0] alu);
    logic memw, pcw, instw, mw, sw, hal, trp;
    logic [2:0] memdst, pcsrc;
    logic [1:0] msrc, ssrc;
    logic [3:0] aop;
    {memw, pcw, instw, mw, sw, hal, trp} = 7'b0;
    memdst = 3'd0; pcsrc = 3'd0; msrc = 2'd0; ssrc = 2'd0; aop = 4'd0;
    case (s)
      S_FETCH: begin pcw = 1'b1; instw = 1'b1; end
      S_LA:    begin pcw = 1'b1; mw = 1'b1; end
      S_LB:    sw = 1'b1;
      S_EX:    aop = alu;
      S_WB:    begin aop = alu; msrc = 2'd1; mw = 1'b1; end
      S_ST:    begin memdst = 3'd3; memw = 1'b1; end
      S_JUMP:  begin pcsrc = 3'd1; pcw = 1'b1; end
      S_HALT:  hal = 1'b1;
      S_TRAP:  begin hal = 1'b1; trp = 1'b1; end
      default: ;
    endcase
    return {memw, pcw, 1'b0, instw, 2'b00, memdst, pcsrc, 3'b000, mw, sw, 1'b0, 1'b0,
            msrc, ssrc, 1'b0, 1'b0, 2'b00, aop, hal, trp};
  endfunction

  // One clock: drive inputs, check outputs against the model, advance the model.
  task automatic cycle(input logic rst, input logic [15:0] ins, input logic ovf);
    int s;
    logic [3:0] op;
    @(negedge clock);
    reset = rst;
    instruction = ins;
    overflow_output = ovf;
    #1;
    if (rst) begin
      check_eq("reset", dut_vec, 33'd0);
      steps.delete();
      stuck = 0;
    end else begin
      if (steps.size() == 0) begin
        steps.push_back(S_FETCH);
        steps.push_back(S_DECODE);
      end
      s = steps.pop_front();
      check_eq(step_name(s), dut_vec, step_vec(s, cur_alu));
      op = ins[15:12];
      case (s)
        S_DECODE: begin
          if (op == 4'h1 || op == 4'h2) begin
            cur_alu = (op == 4'h1) ? 4'd2 : 4'd3;
            steps.push_back(S_LA); steps.push_back(S_LB); steps.push_back(S_EX);
          end else if (op == 4'h3) steps.push_back(S_JUMP);
          else if (op == 4'hF) steps.push_back(S_HALT);
        end
        S_EX: begin
          if (TRAP_EN && ovf) steps.push_back(S_TRAP);
          else begin steps.push_back(S_WB); steps.push_back(S_ST); end
        end
        S_HALT: begin steps.push_back(S_HALT); stuck++; end
        S_TRAP: begin steps.push_back(S_TRAP); stuck++; end
        default: ;
      endcase
    end
  endtask

  initial begin
    logic [15:0] ins;
    logic [3:0]  opc;
    int r;
    repeat (3) cycle(1'b1, 16'h1234, 1'b0);
    repeat (8)  cycle(1'b0, 16'h1000, 1'b0);
    repeat (7)  cycle(1'b0, 16'h2000, 1'b0);
    repeat (3)  cycle(1'b0, 16'h3040, 1'b0);
    repeat (2)  cycle(1'b0, 16'h0000, 1'b0);
    repeat (2)  cycle(1'b0, 16'h7abc, 1'b0);
    repeat (7)  cycle(1'b0, 16'h2000, 1'b1);
    repeat (4)  cycle(1'b0, 16'h2000, 1'b1);
    cycle(1'b1, 16'h0000, 1'b0);
    repeat (22) cycle(1'b0, 16'hF000, 1'b0);
    repeat (2)  cycle(1'b1, 16'hF000, 1'b0);
    repeat (9)  cycle(1'b0, 16'h1000, 1'b0);

    for (int i = 0; i < 3000; i++) begin
      r = $urandom_range(0, 19);
      if (r < 6)       opc = 4'h1;
      else if (r < 10) opc = 4'h2;
      else if (r < 13) opc = 4'h3;
      else if (r < 15) opc = 4'h0;
      else if (r == 15) opc = 4'hF;
      else             opc = 4'($urandom_range(0, 15));
      ins = {opc, 12'($urandom_range(0, 4095))};
      cycle(($urandom_range(0, 49) == 0) || (stuck > 8), ins,
            1'($urandom_range(0, 3) == 0));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
